bus_merge: RTL

- Inverse of the instruction bus splitter: packs a 4-bit opcode and an 8-bit operand into one 12-bit Tiny-CPU instruction word {instruction, data}.
- Buffers packed words in a small FIFO with valid/ready on both sides.
- Tags each outgoing word with a sequential program address so a loader can stream words into instruction memory.

---
 rtl/bus_merge_if.sv | 28 ++
 rtl/bus_merge.sv | 115 +++++++++++
 2 files changed

// File: rtl/bus_merge_if.sv
// Handshake bundle for bus_merge: producer side (opcode/operand in) and
// loader side (packed word, program address, occupancy out).
interface bus_merge_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [3:0]        instruction;
  logic [7:0]        data;
  logic              in_valid;
  logic              in_ready;
  logic [11:0]       bus_output;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] word_addr;
  logic [CNT_W-1:0]  count;

  modport master (
    output instruction, data, in_valid, out_ready,
    input  in_ready, bus_output, out_valid, word_addr, count
  );

  modport slave (
    input  instruction, data, in_valid, out_ready,
    output in_ready, bus_output, out_valid, word_addr, count
  );
endinterface

// File: rtl/bus_merge.sv
// Packs {opcode, operand} into 12-bit Tiny-CPU words, buffers them in a FIFO and
// tags each popped word with a program address. Optional BUS_MERGE_CHECKSUM_EN adds a running XOR.
module bus_merge #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  bus_merge_if.slave  bus
`ifdef BUS_MERGE_CHECKSUM_EN
  ,
  output logic [11:0] checksum
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [11:0]       mem_q [DEPTH];
  logic [11:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       cks_q, cks_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [11:0]       bus_output_q, bus_output_d;
  logic              push_s;
  logic              pop_s;

  assign push_s = bus.in_valid & in_ready_q;
  assign pop_s  = out_valid_q & bus.out_ready;

  // Next-state: flush, push/pop bookkeeping, then the registered output views.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    cks_d    = cks_q;
    if (clear) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      addr_d   = {ADDR_W{1'b0}};
      cks_d    = 12'h000;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {bus.instruction, bus.data};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(1);
        cks_d    = cks_q ^ bus_output_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != {CNT_W{1'b0}});
    // Head is taken from next-state storage so a fresh push is visible right after its edge.
    if (out_valid_d) begin
      bus_output_d = mem_d[rd_ptr_d];
    end else begin
      bus_output_d = 12'h000;
    end
  end

  // State registers with synchronous reset; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      cks_q        <= 12'h000;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      bus_output_q <= 12'h000;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      cks_q        <= cks_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      bus_output_q <= bus_output_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.bus_output = bus_output_q;
  assign bus.word_addr  = addr_q;
  assign bus.count      = count_q;

`ifdef BUS_MERGE_CHECKSUM_EN
  assign checksum = cks_q;
`else
  logic unused_cks_s;
  assign unused_cks_s = ^cks_q;
`endif
endmodule
